fsm3_dispatch_ctrl: RTL and testbench

- Sequencer that accepts decoded 2-bit instructions from get_command and launches exactly one FSM3 module (STP, EVP or EVB) per instruction.
- Waits for the launched module to finish, then commits that module's final read address into the FSM2 current read-address register.
- Drives the instr select that steers rd_addr_data_MUX, so only one FSM3 module owns the data-buffer read port at a time.
- Handles the RST instruction (2'b11) locally by clearing the read pointer.

---
 rtl/fsm3_dispatch_ctrl_if.sv | 38 +++
 rtl/fsm3_dispatch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fsm3_dispatch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm3_dispatch_ctrl_if.sv
// Bundle of command handshake, FSM3 launch/done, read-address and status signals for fsm3_dispatch_ctrl.
// slave is the dispatcher side; master is the command source plus the FSM3 modules.
interface fsm3_dispatch_ctrl_if #(
    parameter int AW = 10
);
    logic          cmd_valid;
    logic [1:0]    cmd_instr;
    logic          cmd_ready;
    logic          start_STP;
    logic          start_EVP;
    logic          start_EVB;
    logic          done_STP;
    logic          done_EVP;
    logic          done_EVB;
    logic [AW-1:0] rd_addr_data_STP;
    logic [AW-1:0] rd_addr_data_EVP;
    logic [AW-1:0] rd_addr_data_EVB;
    logic [1:0]    instr_sel;
    logic [AW-1:0] rd_addr_data_cur;
    logic          cmd_done;
    logic [15:0]   cmd_count;
    logic          err;
    logic          timeout;

    modport master (
        output cmd_valid, cmd_instr, done_STP, done_EVP, done_EVB,
               rd_addr_data_STP, rd_addr_data_EVP, rd_addr_data_EVB,
        input  cmd_ready, start_STP, start_EVP, start_EVB, instr_sel,
               rd_addr_data_cur, cmd_done, cmd_count, err, timeout
    );

    modport slave (
        input  cmd_valid, cmd_instr, done_STP, done_EVP, done_EVB,
               rd_addr_data_STP, rd_addr_data_EVP, rd_addr_data_EVB,
        output cmd_ready, start_STP, start_EVP, start_EVB, instr_sel,
               rd_addr_data_cur, cmd_done, cmd_count, err, timeout
    );
endinterface

// File: rtl/fsm3_dispatch_ctrl.sv
// Dispatches STP/EVP/EVB/RST instructions to the FSM3 modules and commits the returned read pointer.
// Optional WAIT watchdog enabled by defining DISPATCH_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for cmd_valid
//   LAUNCH | one-cycle start pulse to the selected FSM3 module
//   WAIT   | waiting for done of the active module
//   CLEAR  | RST instruction: clear read pointer, complete command
module fsm3_dispatch_ctrl #(
    parameter int buffer_size    = 1024,
    parameter int timeout_cycles = 4096
) (
    input logic                  clk,
    input logic                  rst,
    fsm3_dispatch_ctrl_if.slave  bus
);
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int AW = log2(buffer_size);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_CLEAR  = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic [1:0]    instr_sel_q, instr_sel_d;
    logic [AW-1:0] ptr_q,       ptr_d;
    logic [15:0]   cnt_q,       cnt_d;
    logic [2:0]    start_q,     start_d;
    logic          cmd_done_q,  cmd_done_d;
    logic          err_q,       err_d;

    logic [2:0]    done_vec;
    logic [2:0]    sel_onehot;
    logic          active_done;
    logic          stray_done;
    logic [AW-1:0] rd_addr_sel;

`ifdef DISPATCH_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIM = 32'(timeout_cycles);
    logic [31:0]   wd_cnt_q,    wd_cnt_d;
    logic          timeout_q,   timeout_d;
`endif

    // Index 3 (RST) never reaches WAIT, so its empty one-hot is harmless.
    assign done_vec    = {bus.done_EVB, bus.done_EVP, bus.done_STP};
    assign sel_onehot  = 3'b001 << instr_sel_q;
    assign active_done = |(done_vec & sel_onehot);
    assign stray_done  = |(done_vec & ~sel_onehot);

    always_comb begin
        case (instr_sel_q)
            2'b00:   rd_addr_sel = bus.rd_addr_data_STP;
            2'b01:   rd_addr_sel = bus.rd_addr_data_EVP;
            default: rd_addr_sel = bus.rd_addr_data_EVB;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_sel_d = instr_sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        start_d     = 3'b000;
        cmd_done_d  = 1'b0;
        err_d       = err_q;
`ifdef DISPATCH_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    instr_sel_d = bus.cmd_instr;
                    if (bus.cmd_instr == 2'b11) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = 3'b001 << bus.cmd_instr;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                wd_cnt_d = 32'd0;
`endif
            end
            S_WAIT: begin
                if (stray_done) err_d = 1'b1;
                if (active_done) begin
                    ptr_d      = rd_addr_sel;
                    cmd_done_d = 1'b1;
                    cnt_d      = cnt_q + 16'd1;
                    state_d    = S_IDLE;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (wd_cnt_q + 32'd1 >= TIMEOUT_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
`endif
            end
            S_CLEAR: begin
                ptr_d      = '0;
                cmd_done_d = 1'b1;
                cnt_d      = cnt_q + 16'd1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            instr_sel_q <= 2'b00;
            ptr_q       <= '0;
            cnt_q       <= 16'd0;
            start_q     <= 3'b000;
            cmd_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_sel_q <= instr_sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            cmd_done_q  <= cmd_done_d;
            err_q       <= err_d;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_q  <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.cmd_ready        = (state_q == S_IDLE);
    assign bus.start_STP        = start_q[0];
    assign bus.start_EVP        = start_q[1];
    assign bus.start_EVB        = start_q[2];
    assign bus.instr_sel        = instr_sel_q;
    assign bus.rd_addr_data_cur = ptr_q;
    assign bus.cmd_done         = cmd_done_q;
    assign bus.cmd_count        = cnt_q;
    assign bus.err              = err_q;
endmodule

// File: tb/tb_fsm3_dispatch_ctrl.sv
// Self-checking bench for fsm3_dispatch_ctrl: directed scenarios plus random instruction stream.
// Watchdog scenarios are compiled in only when DISPATCH_TIMEOUT_EN is defined.
module tb_fsm3_dispatch_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Transaction-level expectations
    logic [9:0]  exp_ptr;
    logic [15:0] exp_cnt;
    logic        exp_err;

    fsm3_dispatch_ctrl_if #(.AW(10)) bus ();

    fsm3_dispatch_ctrl #(
        .buffer_size   (1024),
        .timeout_cycles(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_done(input int idx, input logic v);
        case (idx)
            0:       bus.done_STP = v;
            1:       bus.done_EVP = v;
            default: bus.done_EVB = v;
        endcase
    endtask

    task automatic set_addr(input int idx, input logic [9:0] a);
        case (idx)
            0:       bus.rd_addr_data_STP = a;
            1:       bus.rd_addr_data_EVP = a;
            default: bus.rd_addr_data_EVB = a;
        endcase
    endtask

    function automatic logic [2:0] starts();
        return {bus.start_EVB, bus.start_EVP, bus.start_STP};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_ptr = '0;
        exp_cnt = '0;
        exp_err = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, bus.cmd_ready, 1);
        chk({tag, "_ptr"}, bus.rd_addr_data_cur, exp_ptr);
        chk({tag, "_cnt"}, bus.cmd_count, exp_cnt);
        chk({tag, "_start"}, starts(), 0);
        chk({tag, "_err"}, bus.err, exp_err);
        chk({tag, "_done"}, bus.cmd_done, 0);
    endtask

    // One instruction from acceptance to completion; timing follows the documented latency rules.
    task automatic run_cmd(input logic [1:0] instr, input logic [9:0] addr,
                           input int delay, input bit stray, input bit early);
        logic [2:0] onehot;
        int other;
        onehot = (instr == 2'b11) ? 3'b000 : (3'b001 << instr);
        other  = (int'(instr) + 1 + int'($urandom_range(0, 1))) % 3;
        chk("ready_before", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = instr;
        for (int m = 0; m < 3; m++) set_addr(m, 10'($urandom));
        if (instr != 2'b11) set_addr(int'(instr), addr);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_instr = 2'($urandom);
        chk("instr_sel", bus.instr_sel, instr);
        chk("start_launch", starts(), onehot);
        chk("ready_busy", bus.cmd_ready, 0);
        chk("done_launch", bus.cmd_done, 0);
        if (instr == 2'b11) begin
            tick();
            exp_ptr = '0;
            exp_cnt = exp_cnt + 16'd1;
            chk("rst_done", bus.cmd_done, 1);
            chk("rst_ptr", bus.rd_addr_data_cur, exp_ptr);
            chk("rst_cnt", bus.cmd_count, exp_cnt);
            chk("rst_ready", bus.cmd_ready, 1);
            chk("rst_start", starts(), 0);
        end else begin
            if (early) set_done(int'(instr), 1'b1);
            tick();
            set_done(int'(instr), 1'b0);
            chk("start_wait", starts(), 0);
            chk("ready_wait", bus.cmd_ready, 0);
            chk("done_early", bus.cmd_done, 0);
            for (int i = 0; i < delay; i++) begin
                if (stray && i == 0) begin
                    set_done(other, 1'b1);
                    exp_err = 1'b1;
                end
                tick();
                set_done(other, 1'b0);
                chk("wait_done", bus.cmd_done, 0);
                chk("wait_ready", bus.cmd_ready, 0);
                chk("wait_ptr", bus.rd_addr_data_cur, exp_ptr);
                chk("wait_err", bus.err, exp_err);
            end
            if (stray && delay == 0) begin
                set_done(other, 1'b1);
                exp_err = 1'b1;
            end
            set_done(int'(instr), 1'b1);
            tick();
            set_done(int'(instr), 1'b0);
            set_done(other, 1'b0);
            exp_ptr = addr;
            exp_cnt = exp_cnt + 16'd1;
            chk("commit_done", bus.cmd_done, 1);
            chk("commit_ready", bus.cmd_ready, 1);
            chk("commit_ptr", bus.rd_addr_data_cur, exp_ptr);
            chk("commit_cnt", bus.cmd_count, exp_cnt);
            chk("commit_err", bus.err, exp_err);
            chk("commit_sel", bus.instr_sel, instr);
        end
        tick();
        chk("after_done", bus.cmd_done, 0);
        chk("after_ptr", bus.rd_addr_data_cur, exp_ptr);
        chk("after_cnt", bus.cmd_count, exp_cnt);
        chk("after_sel", bus.instr_sel, instr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_instr = 2'b00;
        bus.done_STP = 1'b0;
        bus.done_EVP = 1'b0;
        bus.done_EVB = 1'b0;
        bus.rd_addr_data_STP = '0;
        bus.rd_addr_data_EVP = '0;
        bus.rd_addr_data_EVB = '0;

        do_reset();
        chk_quiet("reset");
        chk("reset_sel", bus.instr_sel, 0);
        chk("reset_timeout", bus.timeout, 0);

        // Done pulses in IDLE must be ignored
        bus.done_EVB = 1'b1;
        bus.done_STP = 1'b1;
        tick();
        bus.done_EVB = 1'b0;
        bus.done_STP = 1'b0;
        chk_quiet("idle_done");

        run_cmd(2'b01, 10'd37, 3, 1'b0, 1'b0);
        run_cmd(2'b00, 10'd1023, 2, 1'b1, 1'b0);
        chk("stray_err_sticky", bus.err, 1);
        run_cmd(2'b10, 10'd500, 0, 1'b0, 1'b0);
        run_cmd(2'b11, 10'd0, 0, 1'b0, 1'b0);

        // Reset in the middle of an EVB command aborts it
        run_cmd(2'b10, 10'd77, 0, 1'b0, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = 2'b10;
        bus.rd_addr_data_EVB = 10'd321;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_ptr = '0;
        exp_cnt = '0;
        exp_err = 1'b0;
        chk_quiet("midrst");
        chk("midrst_sel", bus.instr_sel, 0);
        bus.done_EVB = 1'b1;
        tick();
        bus.done_EVB = 1'b0;
        chk_quiet("midrst_late_done");

        for (int n = 0; n < 60; n++) begin
            logic [1:0] ins;
            ins = 2'($urandom_range(0, 3));
            run_cmd(ins, 10'($urandom), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                set_done(int'($urandom_range(0, 2)), 1'b1);
                tick();
                bus.done_STP = 1'b0;
                bus.done_EVP = 1'b0;
                bus.done_EVB = 1'b0;
                chk_quiet("rand_idle");
            end
        end

`ifdef DISPATCH_TIMEOUT_EN
        do_reset();
        run_cmd(2'b00, 10'd99, 1, 1'b0, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = 2'b01;
        bus.rd_addr_data_EVP = 10'd200;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("wd_pending", bus.timeout, 0);
            chk("wd_busy", bus.cmd_ready, 0);
        end
        tick();
        chk("wd_timeout", bus.timeout, 1);
        chk_quiet("wd_idle");

        do_reset();
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = 2'b01;
        bus.rd_addr_data_EVP = 10'd200;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        bus.done_EVP = 1'b1;
        tick();
        bus.done_EVP = 1'b0;
        exp_ptr = 10'd200;
        exp_cnt = 16'd1;
        chk("wd_race_timeout", bus.timeout, 0);
        chk("wd_race_done", bus.cmd_done, 1);
        chk("wd_race_ptr", bus.rd_addr_data_cur, exp_ptr);
        chk("wd_race_cnt", bus.cmd_count, exp_cnt);
`else
        // Without the watchdog, WAIT lasts indefinitely
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = 2'b01;
        bus.rd_addr_data_EVP = 10'd200;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("nowd_busy", bus.cmd_ready, 0);
        chk("nowd_timeout", bus.timeout, 0);
        bus.done_EVP = 1'b1;
        tick();
        bus.done_EVP = 1'b0;
        exp_ptr = 10'd200;
        exp_cnt = exp_cnt + 16'd1;
        chk("nowd_done", bus.cmd_done, 1);
        chk("nowd_ptr", bus.rd_addr_data_cur, exp_ptr);
        chk("nowd_cnt", bus.cmd_count, exp_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
